// File: rtl/spi_word_splitter_if.sv
// Bundle between the word splitter, the SPI slave core and the word-wide send/receive buffers.
// The slave modport is the splitter's view; master is the surrounding environment.
interface spi_word_splitter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int CNT_WIDTH      = 16
);
  logic                      spi_cs;
  logic                      spi_ready;
  logic [SPI_DATA_WIDTH-1:0] spi_data_receive;
  logic [SPI_DATA_WIDTH-1:0] spi_data_send;
  logic                      buf_valid;
  logic                      buf_oe;
  logic [DATA_WIDTH-1:0]     buf_data;
  logic                      rx_wr;
  logic [DATA_WIDTH-1:0]     rx_data;
  logic [CNT_WIDTH-1:0]      rx_words;
  logic                      frame_done;
  logic                      tx_underflow;
  logic                      overrun;
  logic                      partial;

  modport slave (
    input  spi_cs, spi_ready, spi_data_receive, buf_valid, buf_data,
    output spi_data_send, buf_oe, rx_wr, rx_data, rx_words,
           frame_done, tx_underflow, overrun, partial
  );

  modport master (
    output spi_cs, spi_ready, spi_data_receive, buf_valid, buf_data,
    input  spi_data_send, buf_oe, rx_wr, rx_data, rx_words,
           frame_done, tx_underflow, overrun, partial
  );
endinterface

// File: rtl/spi_word_splitter.sv
// Splits send-buffer words into SPI bytes (MSB byte first) and packs received SPI
// bytes back into words for the receive buffer, framed by a synchronous chip select.
module spi_word_splitter #(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int CNT_WIDTH      = 16
) (
  input logic clk,
  input logic rst,
  spi_word_splitter_if.slave bus
);
  localparam int BYTES     = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int IDX_WIDTH = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, SHIFT} state_t;

  state_t state, state_nxt;

  logic [IDX_WIDTH-1:0]      byte_idx, idx_nxt;
  logic [DATA_WIDTH-1:0]     tx_shift, tx_next, rx_next;
  logic [SPI_DATA_WIDTH-1:0] spi_data_send;
  logic                      rx_wr, frame_done, tx_underflow, overrun, partial;
  logic [DATA_WIDTH-1:0]     rx_data;
  logic [CNT_WIDTH-1:0]      rx_words;
  logic                      active, byte_take, word_end, cs_drop, buf_oe;

  assign active    = (state != IDLE);
  assign byte_take = active && bus.spi_ready;
  assign word_end  = byte_take && (byte_idx == LAST_IDX);
  assign cs_drop   = active && !bus.spi_cs;
  assign idx_nxt   = word_end ? '0 : (byte_take ? byte_idx + 1'b1 : byte_idx);
  assign tx_next   = tx_shift << SPI_DATA_WIDTH;

  // The rx shift holds only the bytes preceding the current one, so a one-byte word needs none.
  if (BYTES > 1) begin : g_rx_multi
    logic [DATA_WIDTH-SPI_DATA_WIDTH-1:0] rx_hold;
    assign rx_next = {rx_hold, bus.spi_data_receive};
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            rx_hold <= '0;
      else if (cs_drop)   rx_hold <= '0;
      else if (byte_take) rx_hold <= rx_next[DATA_WIDTH-SPI_DATA_WIDTH-1:0];
    end
  end else begin : g_rx_single
    assign rx_next = bus.spi_data_receive;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.spi_cs) state_nxt = FETCH;
      FETCH:   state_nxt = bus.buf_valid ? LATCH : SHIFT;
      LATCH:   state_nxt = SHIFT;
      SHIFT:   if (word_end) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    if (cs_drop) state_nxt = IDLE;
  end

  always_comb begin
    buf_oe = (state == FETCH) && bus.buf_valid && bus.spi_cs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx      <= '0;
      tx_shift      <= '0;
      spi_data_send <= '0;
      rx_wr         <= 1'b0;
      rx_data       <= '0;
      rx_words      <= '0;
      frame_done    <= 1'b0;
      tx_underflow  <= 1'b0;
      overrun       <= 1'b0;
      partial       <= 1'b0;
    end else begin
      rx_wr      <= 1'b0;
      frame_done <= 1'b0;
      if (!active) begin
        spi_data_send <= '0;
        if (bus.spi_cs) begin
          tx_underflow <= 1'b0;
          overrun      <= 1'b0;
          partial      <= 1'b0;
          rx_words     <= '0;
        end
      end else begin
        byte_idx <= idx_nxt;
        if (word_end) begin
          rx_wr   <= 1'b1;
          rx_data <= rx_next;
          if (rx_words != '1) rx_words <= rx_words + 1'b1;
        end
        if (byte_take) begin
          if (state == SHIFT) begin
            tx_shift      <= tx_next;
            spi_data_send <= tx_next[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
          end else begin
            overrun <= 1'b1;
          end
        end
        // A late byte during FETCH/LATCH must not disturb the word load.
        if (bus.spi_cs && state == FETCH && !bus.buf_valid) begin
          tx_shift      <= '0;
          spi_data_send <= '0;
          tx_underflow  <= 1'b1;
        end
        if (bus.spi_cs && state == LATCH) begin
          tx_shift      <= bus.buf_data;
          spi_data_send <= bus.buf_data[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
        end
        if (cs_drop) begin
          frame_done <= 1'b1;
          byte_idx   <= '0;
          if (idx_nxt != '0) partial <= 1'b1;
        end
      end
    end
  end

  assign bus.spi_data_send = spi_data_send;
  assign bus.buf_oe        = buf_oe;
  assign bus.rx_wr         = rx_wr;
  assign bus.rx_data       = rx_data;
  assign bus.rx_words      = rx_words;
  assign bus.frame_done    = frame_done;
  assign bus.tx_underflow  = tx_underflow;
  assign bus.overrun       = overrun;
  assign bus.partial       = partial;
endmodule

// File: tb/tb_spi_word_splitter.sv
// Directed bench for spi_word_splitter (32-bit words, 8-bit SPI bytes) with a small
// queue model of the send buffer.
module tb_spi_word_splitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   oe_cnt   = 0;
  int   oe_base;
  bit   oe_seen  = 1'b0;

  logic [31:0] q[$];
  logic [31:0] mdl_data  = '0;
  logic        mdl_valid = 1'b0;

  spi_word_splitter_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();

  spi_word_splitter #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.buf_data  = mdl_data;
  assign bus.buf_valid = mdl_valid;

  always @(negedge clk) begin
    oe_seen = bus.buf_oe;
    if (bus.buf_oe) oe_cnt++;
  end

  // Send buffer: the word read by buf_oe appears early in the following cycle.
  always @(posedge clk) begin
    #1;
    if (oe_seen && q.size() != 0) mdl_data = q.pop_front();
    oe_seen   = 1'b0;
    mdl_valid = (q.size() != 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d, input logic [7:0] exp_tx, input bit do_chk);
    bus.spi_ready        = 1'b1;
    bus.spi_data_receive = d;
    smp();
    if (do_chk) chk("tx_byte", 64'(bus.spi_data_send), 64'(exp_tx));
    tick();
    bus.spi_ready = 1'b0;
  endtask

  task automatic xfer_word(input logic [31:0] rxw, input logic [31:0] txw);
    for (int i = 0; i < 4; i++) begin
      pulse(rxw[8*(3-i) +: 8], txw[8*(3-i) +: 8], 1'b1);
      if (i < 3) repeat (3) tick();
    end
    smp();
    chk("rx_wr", 64'(bus.rx_wr), 64'd1);
    chk("rx_data", 64'(bus.rx_data), 64'(rxw));
    tick();
  endtask

  task automatic end_frame(input logic exp_partial);
    tick();
    bus.spi_cs = 1'b0;
    tick();
    smp();
    chk("frame_done", 64'(bus.frame_done), 64'd1);
    chk("partial", 64'(bus.partial), 64'(exp_partial));
    tick();
    smp();
    chk("frame_done_end", 64'(bus.frame_done), 64'd0);
    tick();
  endtask

  function automatic logic [63:0] all_out();
    return {bus.spi_data_send, bus.buf_oe, bus.rx_wr, bus.rx_data, bus.rx_words,
            bus.frame_done, bus.tx_underflow, bus.overrun, bus.partial};
  endfunction

  initial begin
    bus.spi_cs           = 1'b0;
    bus.spi_ready        = 1'b0;
    bus.spi_data_receive = '0;
    repeat (2) tick();
    smp();
    chk("reset_outputs", all_out(), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single word
    q.push_back(32'hA1B2C3D4);
    tick();
    oe_base = oe_cnt;
    bus.spi_cs = 1'b1;
    repeat (3) tick();
    xfer_word(32'h11223344, 32'hA1B2C3D4);
    chk("single_oe", 64'(oe_cnt - oe_base), 64'd1);
    chk("single_words", 64'(bus.rx_words), 64'd1);
    tick();
    chk("single_underflow", 64'(bus.tx_underflow), 64'd1);
    end_frame(1'b0);

    // Two words with prefetch; a third word keeps buf_valid high
    q.push_back(32'hA1B2C3D4);
    q.push_back(32'h01020304);
    q.push_back(32'hDEADBEEF);
    tick();
    oe_base = oe_cnt;
    bus.spi_cs = 1'b1;
    repeat (3) tick();
    xfer_word(32'h55667788, 32'hA1B2C3D4);
    tick();
    chk("two_oe_prefetch", 64'(oe_cnt - oe_base), 64'd2);
    xfer_word(32'h99AABBCC, 32'h01020304);
    chk("two_oe_after", 64'(oe_cnt - oe_base), 64'd3);
    chk("two_words", 64'(bus.rx_words), 64'd2);
    chk("two_underflow", 64'(bus.tx_underflow), 64'd0);
    end_frame(1'b0);
    q.delete();

    // Underflow: nothing to send
    tick();
    oe_base = oe_cnt;
    bus.spi_cs = 1'b1;
    repeat (3) tick();
    xfer_word(32'hCAFEF00D, 32'h00000000);
    chk("uf_oe", 64'(oe_cnt - oe_base), 64'd0);
    chk("uf_flag", 64'(bus.tx_underflow), 64'd1);
    chk("uf_words", 64'(bus.rx_words), 64'd1);
    end_frame(1'b0);

    // Abort after two bytes
    q.push_back(32'hA1B2C3D4);
    tick();
    bus.spi_cs = 1'b1;
    tick();
    smp();
    chk("abort_words_clr", 64'(bus.rx_words), 64'd0);
    chk("abort_uf_clr", 64'(bus.tx_underflow), 64'd0);
    repeat (2) tick();
    pulse(8'hAA, 8'hA1, 1'b1);
    repeat (3) tick();
    pulse(8'hBB, 8'hB2, 1'b1);
    smp();
    chk("abort_no_wr", 64'(bus.rx_wr), 64'd0);
    end_frame(1'b1);

    // Overrun at the word boundary, then last byte together with cs fall
    q.push_back(32'h10203040);
    q.push_back(32'h50607080);
    tick();
    bus.spi_cs = 1'b1;
    tick();
    smp();
    chk("partial_clr", 64'(bus.partial), 64'd0);
    repeat (2) tick();
    pulse(8'h01, 8'h10, 1'b1);
    repeat (3) tick();
    pulse(8'h02, 8'h20, 1'b1);
    repeat (3) tick();
    pulse(8'h03, 8'h30, 1'b1);
    repeat (3) tick();
    pulse(8'h04, 8'h40, 1'b1);
    bus.spi_ready        = 1'b1;
    bus.spi_data_receive = 8'hE1;
    smp();
    chk("ovr_wr1", 64'(bus.rx_wr), 64'd1);
    chk("ovr_data1", 64'(bus.rx_data), 64'h01020304);
    tick();
    bus.spi_data_receive = 8'hE2;
    tick();
    bus.spi_ready = 1'b0;
    smp();
    chk("ovr_flag", 64'(bus.overrun), 64'd1);
    repeat (2) tick();
    pulse(8'hE3, 8'h50, 1'b1);
    repeat (2) tick();
    bus.spi_ready        = 1'b1;
    bus.spi_data_receive = 8'hE4;
    bus.spi_cs           = 1'b0;
    smp();
    chk("ovr_tx_last", 64'(bus.spi_data_send), 64'h60);
    tick();
    bus.spi_ready = 1'b0;
    smp();
    chk("ovr_wr2", 64'(bus.rx_wr), 64'd1);
    chk("ovr_data2", 64'(bus.rx_data), 64'hE1E2E3E4);
    chk("ovr_frame_done", 64'(bus.frame_done), 64'd1);
    chk("ovr_partial", 64'(bus.partial), 64'd0);
    chk("ovr_words", 64'(bus.rx_words), 64'd2);
    repeat (2) tick();

    // Reset mid-SHIFT
    q.push_back(32'hA1B2C3D4);
    tick();
    bus.spi_cs = 1'b1;
    repeat (3) tick();
    pulse(8'h11, 8'hA1, 1'b1);
    smp();
    chk("pre_rst_tx", 64'(bus.spi_data_send), 64'hB2);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_async", all_out(), 64'd0);
    q.push_back(32'h0BADF00D);
    tick();
    oe_base = oe_cnt;
    rst = 1'b0;
    repeat (2) tick();
    smp();
    chk("rst_refetch", 64'(oe_cnt - oe_base), 64'd1);
    chk("rst_sticky", 64'({bus.tx_underflow, bus.overrun, bus.partial, bus.frame_done, bus.rx_wr}), 64'd0);
    end_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_word_splitter.md
Name: spi_word_splitter

Overview:
- SPI-side adapter between the word-wide SPI buffers and the byte-wide SPI slave core.
- Transmit path: reads words from the send buffer through an oe/data handshake and serialises each word into SPI_DATA_WIDTH-bit bytes, MSB byte first.
- Receive path: assembles incoming SPI bytes into DATA_WIDTH words and writes each complete word into the receive buffer with a one-cycle write pulse.
- Frame boundaries come from a synchronous chip-select level.

Parameters:
- DATA_WIDTH, 32: word width. Must be an integer multiple of SPI_DATA_WIDTH.
- SPI_DATA_WIDTH, 8: SPI byte width.
- CNT_WIDTH, 16: width of the per-frame received-word counter.
- Derived: BYTES = DATA_WIDTH/SPI_DATA_WIDTH; IDX_WIDTH = $clog2(BYTES), minimum 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset: asynchronous, active-high
- spi_cs  input  1  frame active, high, synchronous to clk
- spi_ready  input  1  one-clk pulse from the SPI core; a byte was exchanged
- spi_data_receive  input  SPI_DATA_WIDTH  byte received, valid with spi_ready
- spi_data_send  output  SPI_DATA_WIDTH  byte to send on the next exchange, registered
- buf_valid  input  1  send buffer holds unread data
- buf_oe  output  1  one-clk read strobe to the send buffer
- buf_data  input  DATA_WIDTH  send-buffer word, valid the cycle after buf_oe
- rx_wr  output  1  one-clk write strobe to the receive buffer
- rx_data  output  DATA_WIDTH  assembled word, valid while rx_wr=1
- rx_words  output  CNT_WIDTH  complete words received in the current frame
- frame_done  output  1  one-clk pulse after spi_cs falls
- tx_underflow  output  1  sticky: a word boundary was reached with buf_valid=0
- overrun  output  1  sticky: spi_ready arrived while not in SHIFT
- partial  output  1  sticky: spi_cs fell with a non-zero byte index

Behaviour:
- Reset values:
  - Every output is 0.
  - State is IDLE; byte index is 0; tx and rx shift registers are 0.
- State IDLE:
  - spi_data_send = 0.
  - On spi_cs rising (spi_cs=1 in IDLE), clear tx_underflow, overrun, partial and rx_words, then go to FETCH.
- State FETCH, one cycle:
  - If buf_valid=1: drive buf_oe=1, go to LATCH.
  - Else: load tx shift with 0, set tx_underflow, go to SHIFT with no buf_oe.
- State LATCH, one cycle:
  - Load tx shift with buf_data.
  - spi_data_send <= buf_data[DATA_WIDTH-1 -: SPI_DATA_WIDTH].
  - Go to SHIFT.
- spi_data_send latency: the first byte of a word is stable 2 clk after FETCH entry.
- SPI core contract: spi_ready pulses must be spaced at least 3 clk apart, and the first pulse must come at least 3 clk after spi_cs rises.
- State SHIFT, on spi_ready:
  - rx shift <= {rx shift, spi_data_receive}.
  - tx shift shifts left by SPI_DATA_WIDTH; spi_data_send <= next MSB byte.
  - Byte index increments.
- End of word (spi_ready with byte index = BYTES-1):
  - Next cycle: rx_wr=1 and rx_data = completed word.
  - rx_words increments, saturating at all-ones.
  - Byte index wraps to 0; state goes to FETCH (prefetch of the next word).
- spi_ready outside SHIFT (in FETCH or LATCH, spi_cs high):
  - Set overrun.
  - The rx byte is still captured and the byte index still advances; an end-of-word pulse is still generated.
  - The tx load proceeds unchanged.
- spi_ready and spi_cs falling in the same cycle: the byte is processed first, including any rx_wr, then the block enters IDLE.
- spi_cs low in any non-IDLE state:
  - Go to IDLE; frame_done pulses one cycle later.
  - If the byte index is non-zero after that cycle's processing, set partial and discard the partial rx word.
  - Any pending buf_oe is not issued; a word already read but not fully sent is lost. The word-granular buffer owns retry.
- BYTES=1: every spi_ready completes a word.
- rx_wr and buf_oe may be high in the same cycle.
- rst mid-frame: immediate return to reset values; no rx_wr or frame_done is generated for the aborted frame.

Test Plan (DATA_WIDTH=32, SPI_DATA_WIDTH=8):
- Reset: assert rst mid-SHIFT with spi_cs=1 -> all outputs 0 immediately; after release with spi_cs=1, FETCH runs again and stickies clear.
- Single word: buffer 0xA1B2C3D4 with buf_valid=1; cs high; 4 ready pulses 4 clk apart with rx bytes 11,22,33,44.
  - spi_data_send sequence is A1,B2,C3,D4.
  - One buf_oe before the first byte.
  - rx_wr one clk after the 4th ready with rx_data=0x11223344; rx_words=1.
  - cs low -> frame_done pulse, partial=0.
- Two words: buffer 0xA1B2C3D4, 0x01020304; 8 ready pulses.
  - Sends A1..D4 then 01..04.
  - Exactly 2 buf_oe pulses before the 5th ready (prefetch), plus 1 more after the 8th if buf_valid remains high.
  - rx_words=2.
- Underflow: buf_valid=0 at cs rise -> no buf_oe; bytes 00,00,00,00 sent; tx_underflow=1; rx_wr still fires.
- Abort: cs falls after 2 ready pulses -> no rx_wr; partial=1; frame_done pulse; the next cs rise clears partial and rx_words.
- Overrun: ready pulses 1 clk apart at the word boundary -> overrun=1; rx_data still equals the assembled bytes; same-cycle ready and cs fall on the 4th byte -> rx_wr fires, partial=0.
